// File: rtl/mac_seq_ctrl_if.sv
// Signal bundle between the sequencer (master) and the layer controller, operand buffers, MAC lane and result consumer (slave).
interface mac_seq_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len;
  logic [ADDR_W-1:0] cmd_base_a;
  logic [ADDR_W-1:0] cmd_base_b;
  logic [4:0]        cmd_shift;

  logic              a_rd_en;
  logic [ADDR_W-1:0] a_rd_addr;
  logic [15:0]       a_rd_data;
  logic              b_rd_en;
  logic [ADDR_W-1:0] b_rd_addr;
  logic [15:0]       b_rd_data;

  logic [15:0]       mac_operand_a;
  logic [15:0]       mac_operand_b;
  logic              mac_clk_en;
  logic              mac_start;
  logic              mac_stop;
  logic [4:0]        mac_right_shift;
  logic [15:0]       mac_out;
  logic              mac_output_valid;

  logic              res_valid;
  logic              res_ready;
  logic [15:0]       res_data;
  logic              err_timeout;

  modport master (
    input  cmd_valid, cmd_len, cmd_base_a, cmd_base_b, cmd_shift,
    input  a_rd_data, b_rd_data, mac_out, mac_output_valid, res_ready,
    output cmd_ready, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
    output mac_operand_a, mac_operand_b, mac_clk_en, mac_start, mac_stop, mac_right_shift,
    output res_valid, res_data, err_timeout
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_base_a, cmd_base_b, cmd_shift,
    output a_rd_data, b_rd_data, mac_out, mac_output_valid, res_ready,
    input  cmd_ready, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
    input  mac_operand_a, mac_operand_b, mac_clk_en, mac_start, mac_stop, mac_right_shift,
    input  res_valid, res_data, err_timeout
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer for one MAC lane: result valid len+MULT_CYCLES+2 cycles after accept (1 cycle for len=0).
// Backpressure: no new command is taken until the held result is consumed via res_ready.
module mac_seq_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int LEN_W       = 10,
  parameter int MULT_CYCLES = 6
) (
  input  logic           clk,
  input  logic           rst,
  mac_seq_ctrl_if.master bus
);
  localparam int CNT_W = $clog2(MULT_CYCLES + 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  k;
  logic [CNT_W-1:0]  wait_cnt;
  logic              first_rd;
  logic              last_rd;

  // Buffer data arrives one cycle after the read strobe, so the MAC controls are the read-side flags delayed by one.
  assign first_rd = bus.a_rd_en && (k == '0);
  assign last_rd  = bus.a_rd_en && (k == len_q - LEN_W'(1));

  assign bus.mac_operand_a = bus.a_rd_data;
  assign bus.mac_operand_b = bus.b_rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      len_q               <= '0;
      k                   <= '0;
      wait_cnt            <= '0;
      bus.cmd_ready       <= 1'b1;
      bus.a_rd_en         <= 1'b0;
      bus.b_rd_en         <= 1'b0;
      bus.a_rd_addr       <= '0;
      bus.b_rd_addr       <= '0;
      bus.mac_clk_en      <= 1'b0;
      bus.mac_start       <= 1'b0;
      bus.mac_stop        <= 1'b0;
      bus.mac_right_shift <= '0;
      bus.res_valid       <= 1'b0;
      bus.res_data        <= '0;
      bus.err_timeout     <= 1'b0;
    end else begin
      bus.mac_clk_en <= bus.a_rd_en;
      bus.mac_start  <= first_rd;
      bus.mac_stop   <= last_rd;

      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            bus.cmd_ready       <= 1'b0;
            len_q               <= bus.cmd_len;
            k                   <= '0;
            bus.mac_right_shift <= bus.cmd_shift;
            if (bus.cmd_len == '0) begin
              bus.res_data  <= '0;
              bus.res_valid <= 1'b1;
              state         <= RESULT;
            end else begin
              bus.a_rd_en   <= 1'b1;
              bus.b_rd_en   <= 1'b1;
              bus.a_rd_addr <= bus.cmd_base_a;
              bus.b_rd_addr <= bus.cmd_base_b;
              state         <= ISSUE;
            end
          end
        end

        ISSUE: begin
          if (k == len_q - LEN_W'(1)) begin
            bus.a_rd_en <= 1'b0;
            bus.b_rd_en <= 1'b0;
            wait_cnt    <= '0;
            state       <= WAIT;
          end else begin
            k             <= k + LEN_W'(1);
            bus.a_rd_addr <= bus.a_rd_addr + ADDR_W'(1);
            bus.b_rd_addr <= bus.b_rd_addr + ADDR_W'(1);
          end
        end

        // WAIT is entered in the mac_stop cycle, so wait_cnt counts cycles since stop.
        WAIT: begin
          if (bus.mac_output_valid) begin
            bus.res_data  <= bus.mac_out;
            bus.res_valid <= 1'b1;
            state         <= RESULT;
          end else if (wait_cnt == CNT_W'(MULT_CYCLES + 1)) begin
            bus.err_timeout <= 1'b1;
            bus.res_data    <= '0;
            bus.res_valid   <= 1'b1;
            state           <= RESULT;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        RESULT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
